// File: rtl/fetch_controller.sv
// fetch_controller
//   Owns the fetch program counter. It issues one instruction-memory request
//   at a time over a req/ack handshake and hands each fetched word to decode
//   over a valid/ready handshake. Branch, jump and trap redirects are applied
//   in every state. If a redirect arrives while a request is still waiting for
//   its ack, that request is allowed to finish, and its response is discarded.
//
// Parameters
//   BOOT_ADDRESS   PC value loaded on reset
//
// Ports
//   clk            in   1   system clock
//   reset          in   1   synchronous, active-high reset
//   redirect_valid in   1   one-cycle pulse: redirect_addr becomes the next fetch PC
//   redirect_addr  in   32  redirect target
//   imem_req       out  1   fetch request, held until imem_ack
//   imem_addr      out  32  fetch address, stable while imem_req=1
//   imem_ack       in   1   one-cycle response strobe
//   imem_rdata     in   32  instruction word, valid with imem_ack
//   instr_valid    out  1   instr/instr_pc valid for decode
//   instr_ready    in   1   decode accepts instr this cycle
//   instr          out  32  fetched instruction
//   instr_pc       out  32  address instr was fetched from
//   pc             out  32  architectural next-fetch address
//   trap_vector    in   32  handler for misaligned redirect targets   (FETCH_MISALIGN_TRAP_EN)
//   misalign_trap  out  1   one-cycle misaligned-target trap pulse    (FETCH_MISALIGN_TRAP_EN)
//   trap_tval      out  32  offending redirect target                 (FETCH_MISALIGN_TRAP_EN)
//
// Configuration
//   FETCH_MISALIGN_TRAP_EN  When this macro is defined, a redirect whose target
//                           has nonzero low bits is sent to trap_vector and
//                           raises misalign_trap. When it is undefined, the
//                           trap ports do not exist and the low two bits of
//                           every redirect target are cleared.

module fetch_controller #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    input  logic [31:0] trap_vector,
    output logic        misalign_trap,
    output logic [31:0] trap_tval
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FLUSH = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic [31:0] addr_r;
    logic [31:0] addr_s;
    logic [31:0] instr_r;
    logic [31:0] instr_s;
    logic [31:0] instr_pc_r;
    logic [31:0] instr_pc_s;
    logic        valid_r;
    logic        valid_s;
    logic        req_r;
    logic        req_s;
    logic [31:0] target_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_s;
    logic        trap_r;
    logic [31:0] tval_r;

    // Redirect target: a misaligned target goes to the (word-aligned) trap vector.
    always_comb begin
        misaligned_s = (redirect_addr[1:0] != 2'b00);
        if (misaligned_s) begin
            target_s = trap_vector & 32'hFFFF_FFFC;
        end else begin
            target_s = redirect_addr;
        end
    end

    // Trap pulse and trap value registers; tval is held until the next trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            trap_r <= 1'b0;
            tval_r <= 32'h0000_0000;
        end else begin
            trap_r <= redirect_valid & misaligned_s;
            if (redirect_valid && misaligned_s) begin
                tval_r <= redirect_addr;
            end
        end
    end

    assign misalign_trap = trap_r;
    assign trap_tval     = tval_r;
`else
    // Redirect target: the low two bits are cleared because fetch is word-aligned.
    always_comb begin
        target_s = redirect_addr & 32'hFFFF_FFFC;
    end
`endif

    // Next-state and next-value logic for the fetch sequencer.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        addr_s     = addr_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        valid_s    = valid_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                if (redirect_valid) begin
                    pc_s   = target_s;
                    addr_s = target_s;
                end else begin
                    addr_s = pc_r;
                end
            end
            ST_FETCH: begin
                if (redirect_valid && imem_ack) begin
                    // The request finished in the same cycle, so the new
                    // fetch can start at once. The response is dropped.
                    pc_s   = target_s;
                    addr_s = target_s;
                end else if (redirect_valid) begin
                    // The request is still outstanding. Keep it on the bus
                    // until it is acked, then fetch from the new pc.
                    pc_s    = target_s;
                    state_s = ST_FLUSH;
                end else if (imem_ack) begin
                    instr_s    = imem_rdata;
                    instr_pc_s = addr_r;
                    valid_s    = 1'b1;
                    state_s    = ST_HOLD;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (imem_ack) begin
                    state_s = ST_FETCH;
                    if (redirect_valid) begin
                        pc_s   = target_s;
                        addr_s = target_s;
                    end else begin
                        addr_s = pc_r;
                    end
                end else if (redirect_valid) begin
                    pc_s = target_s;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    // The held word is dropped even if decode is ready in this cycle.
                    valid_s = 1'b0;
                    pc_s    = target_s;
                    addr_s  = target_s;
                    state_s = ST_FETCH;
                end else if (instr_ready) begin
                    valid_s = 1'b0;
                    pc_s    = pc_r + 32'd4;
                    addr_s  = pc_r + 32'd4;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
            end
        endcase
        req_s = (state_s == ST_FETCH) || (state_s == ST_FLUSH);
    end

    // State and datapath registers; reset overrides everything, including a pending ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= BOOT_ADDRESS;
            addr_r     <= BOOT_ADDRESS;
            instr_r    <= 32'h0000_0000;
            instr_pc_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            addr_r     <= addr_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
            valid_r    <= valid_s;
            req_r      <= req_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic [31:0] trap_vector;
    logic        misalign_trap;
    logic [31:0] trap_tval;
    logic        trap1;
    logic [31:0] tval1;
`endif

    // Second instance: the boot address is at the top of the address space.
    // Its memory always acks in the first cycle of a request, and decode is always ready.
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] rdata1;
    logic        valid1;
    logic [31:0] instr1;
    logic [31:0] instr_pc1;
    logic [31:0] pc1;

    int checks   = 0;
    int failures = 0;

    // The instruction memory holds a word that can be computed from its address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign rdata1 = word_at(addr1);

    fetch_controller #(.BOOT_ADDRESS(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .pc(pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .trap_vector(trap_vector), .misalign_trap(misalign_trap), .trap_tval(trap_tval)
`endif
    );

    fetch_controller #(.BOOT_ADDRESS(32'hFFFF_FFFC)) dut_top (
        .clk(clk), .reset(reset),
        .redirect_valid(1'b0), .redirect_addr(32'h0000_0000),
        .imem_req(req1), .imem_addr(addr1),
        .imem_ack(req1), .imem_rdata(rdata1),
        .instr_valid(valid1), .instr_ready(1'b1),
        .instr(instr1), .instr_pc(instr_pc1), .pc(pc1)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .trap_vector(32'h0000_0000), .misalign_trap(trap1), .trap_tval(tval1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then wait until just after the next rising edge.
    task automatic drive(input logic ack, input logic rdy, input logic rv, input logic [31:0] ra);
        imem_ack       = ack;
        imem_rdata     = word_at(imem_addr);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] model_pc;
        logic [31:0] prev_addr;
        logic [31:0] ra;
        logic [31:0] tgt;
        logic [31:0] exp_tval;
        logic        prev_pending;
        logic        ack;
        logic        rdy;
        logic        rv;
        logic        exp_trap;
        int          stall;
        int          accepts;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0000_0000;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0000_0000;
        instr_ready    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap_vector    = 32'h0000_0083;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check32("rst_pc", pc, 32'h0000_0000);
        check32("rst_addr", imem_addr, 32'h0000_0000);
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_instr", instr, 32'h0000_0000);
        check32("rst_instr_pc", instr_pc, 32'h0000_0000);
        check32("rst_top_pc", pc1, 32'hFFFF_FFFC);
        check32("rst_top_addr", addr1, 32'hFFFF_FFFC);
        check1("rst_top_req", req1, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check1("rst_trap", misalign_trap, 1'b0);
        check32("rst_tval", trap_tval, 32'h0000_0000);
        check1("rst_top_trap", trap1, 1'b0);
`endif
        reset = 1'b0;

        // Sequential fetch with the ack one cycle after req: 3 cycles per instruction
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check1("seq_req0", imem_req, 1'b1);
        check32("seq_addr0", imem_addr, 32'h0000_0000);
        check1("top_req0", req1, 1'b1);
        check32("top_addr0", addr1, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check1("seq_req0_held", imem_req, 1'b1);
        check32("seq_addr0_held", imem_addr, 32'h0000_0000);
        check1("top_valid0", valid1, 1'b1);
        check32("top_instr_pc0", instr_pc1, 32'hFFFF_FFFC);
        check32("top_instr0", instr1, word_at(32'hFFFF_FFFC));
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check1("seq_valid0", instr_valid, 1'b1);
        check32("seq_instr0", instr, word_at(32'h0000_0000));
        check32("seq_instr_pc0", instr_pc, 32'h0000_0000);
        check1("seq_req_low", imem_req, 1'b0);
        check1("top_req1", req1, 1'b1);
        check32("top_addr_wrap", addr1, 32'h0000_0000);
        check32("top_pc_wrap", pc1, 32'h0000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
        check1("top_no_trap", trap1, 1'b0);
`endif
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check1("seq_req4", imem_req, 1'b1);
        check32("seq_addr4", imem_addr, 32'h0000_0004);
        check32("seq_pc4", pc, 32'h0000_0004);
        check1("seq_valid_drop", instr_valid, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check1("seq_valid4", instr_valid, 1'b1);
        check32("seq_instr_pc4", instr_pc, 32'h0000_0004);
        check32("seq_instr4", instr, word_at(32'h0000_0004));
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check1("seq_req8", imem_req, 1'b1);
        check32("seq_addr8", imem_addr, 32'h0000_0008);

        // Redirect to 0x100 while the fetch at 0x8 is pending
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        check1("flush_req", imem_req, 1'b1);
        check32("flush_addr_held", imem_addr, 32'h0000_0008);
        check32("flush_pc", pc, 32'h0000_0100);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check1("flush_req_held", imem_req, 1'b1);
        check32("flush_addr_held2", imem_addr, 32'h0000_0008);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check1("flush_no_valid", instr_valid, 1'b0);
        check1("flush_next_req", imem_req, 1'b1);
        check32("flush_next_addr", imem_addr, 32'h0000_0100);

        // Ack in the first cycle of req, then decode stalls for 5 cycles
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check1("fast_valid", instr_valid, 1'b1);
        check32("fast_instr", instr, word_at(32'h0000_0100));
        check32("fast_instr_pc", instr_pc, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check1("stall_valid", instr_valid, 1'b1);
            check32("stall_instr", instr, word_at(32'h0000_0100));
            check32("stall_instr_pc", instr_pc, 32'h0000_0100);
            check32("stall_pc", pc, 32'h0000_0100);
            check1("stall_no_req", imem_req, 1'b0);
        end

        // Redirect to 0x200 while holding, with decode ready in the same cycle
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check1("hold_redir_drop", instr_valid, 1'b0);
        check1("hold_redir_req", imem_req, 1'b1);
        check32("hold_redir_addr", imem_addr, 32'h0000_0200);
        check32("hold_redir_pc", pc, 32'h0000_0200);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check1("hold_redir_valid", instr_valid, 1'b1);
        check32("hold_redir_instr_pc", instr_pc, 32'h0000_0200);

        // Misaligned redirect target 0x102
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        check1("mis_drop", instr_valid, 1'b0);
        check1("mis_req", imem_req, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check32("mis_addr", imem_addr, 32'h0000_0080);
        check32("mis_pc", pc, 32'h0000_0080);
        check1("mis_trap", misalign_trap, 1'b1);
        check32("mis_tval", trap_tval, 32'h0000_0102);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        check1("mis_trap_pulse", misalign_trap, 1'b0);
        check32("mis_tval_held", trap_tval, 32'h0000_0102);
`else
        check32("mis_addr", imem_addr, 32'h0000_0100);
        check32("mis_pc", pc, 32'h0000_0100);
`endif

        // Random traffic compared against a program-flow reference model
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        reset        = 1'b0;
        model_pc     = 32'h0000_0000;
        prev_pending = 1'b0;
        prev_addr    = 32'h0000_0000;
        exp_trap     = 1'b0;
        exp_tval     = 32'h0000_0000;
        stall        = 0;
        accepts      = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check32("rnd_pc", pc, model_pc);
            check1("rnd_req_valid_excl", imem_req & instr_valid, 1'b0);
            if (prev_pending) begin
                check1("rnd_req_held", imem_req, 1'b1);
                check32("rnd_addr_held", imem_addr, prev_addr);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            check1("rnd_trap", misalign_trap, exp_trap);
            check32("rnd_tval", trap_tval, exp_tval);
`endif
            checks++;
            assert (stall < 200) else begin
                failures++;
                $error("FAIL rnd_progress: observed=%0d stalled cycles expected=<200", stall);
            end

            ack = imem_req && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 1) == 1);
            rv  = ($urandom_range(0, 15) == 0);
            ra  = 32'($urandom_range(0, 4095));
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = (ra[1:0] != 2'b00) ? 32'h0000_0080 : ra;
            if (rv && ra[1:0] != 2'b00) begin
                exp_tval = ra;
            end
            exp_trap = rv && (ra[1:0] != 2'b00);
`else
            tgt = {ra[31:2], 2'b00};
            exp_trap = 1'b0;
`endif
            if (instr_valid && rdy && !rv) begin
                check32("rnd_instr_pc", instr_pc, model_pc);
                check32("rnd_instr", instr, word_at(model_pc));
                model_pc = model_pc + 32'd4;
                accepts++;
                stall = 0;
            end else begin
                stall++;
            end
            if (rv) begin
                model_pc = tgt;
            end
            prev_pending = imem_req && !ack;
            prev_addr    = imem_addr;
            drive(ack, rdy, rv, ra);
        end
        checks++;
        assert (accepts > 100) else begin
            failures++;
            $error("FAIL rnd_accepts: observed=%0d expected=>100", accepts);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
